m68k_region_decoder: RTL and testbench

// Parametrised, registered successor to the fixed 68K chip-select decode: N regions held in a runtime table
// (base, match width, wait states, enable), loaded per PCB by the top level.

---
 rtl/m68k_bus_pkg.sv | 41 ++++
 rtl/region_match.sv | 46 ++++
 rtl/m68k_region_decoder.sv | 173 +++++++++++++++++
 tb/tb_m68k_region_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | m68k_bus_pkg                                                           |
// | FSM encoding, region index names and per-PCB default decode tables.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package m68k_bus_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MATCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_MISS  = 3'd4;
    localparam logic [2:0] ST_BERR  = 3'd5;

    localparam int REG_PROG_ROM   = 0;
    localparam int REG_RAM        = 1;
    localparam int REG_SHARED_RAM = 2;
    localparam int REG_VDP        = 3;
    localparam int REG_IO         = 4;
    localparam int PCB_REGIONS    = 5;

    // Flat tables, region 0 in the least significant slot (24-bit address, 4-bit waits).
    localparam logic [PCB_REGIONS*24-1:0] TRUXTON_BASE =
        {24'h1C0000, 24'h140000, 24'h180000, 24'h080000, 24'h000000};
    localparam logic [PCB_REGIONS*5-1:0]  TRUXTON_WIDTH =
        {5'd6, 5'd4, 5'd12, 5'd14, 5'd18};
    localparam logic [PCB_REGIONS*4-1:0]  TRUXTON_WAIT =
        {4'd0, 4'd1, 4'd1, 4'd0, 4'd0};
    localparam logic [PCB_REGIONS-1:0]    TRUXTON_EN = 5'b11111;

    localparam logic [PCB_REGIONS*24-1:0] RALLYBIKE_BASE =
        {24'h1C0000, 24'h140000, 24'h100000, 24'h080000, 24'h000000};
    localparam logic [PCB_REGIONS*5-1:0]  RALLYBIKE_WIDTH =
        {5'd6, 5'd4, 5'd12, 5'd14, 5'd19};
    localparam logic [PCB_REGIONS*4-1:0]  RALLYBIKE_WAIT =
        {4'd0, 4'd2, 4'd1, 4'd0, 4'd1};
    localparam logic [PCB_REGIONS-1:0]    RALLYBIKE_EN = 5'b11111;

endpackage
`default_nettype wire

// File: rtl/region_match.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | region_match                                                           |
// | Combinational region compare with lowest-index priority encoder.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module region_match #(
    parameter int N_REGIONS = 32,
    parameter int ADDR_W    = 24
) (
    input  logic [ADDR_W-1:0]           i_addr,
    input  logic [N_REGIONS*ADDR_W-1:0] i_region_base,
    input  logic [N_REGIONS*5-1:0]      i_region_width,
    input  logic [N_REGIONS-1:0]        i_region_en,
    output logic                        o_hit,
    output logic [5:0]                  o_idx
);

    localparam logic [5:0] c_addr_w = 6'(ADDR_W);

    logic [N_REGIONS-1:0] w_hits;

    for (genvar g = 0; g < N_REGIONS; g++) begin : g_cmp
        logic [4:0]        w_width;
        logic [ADDR_W-1:0] w_base;
        assign w_width   = i_region_width[g*5 +: 5];
        assign w_base    = i_region_base[g*ADDR_W +: ADDR_W];
        // A width covering the whole bus turns the region into a catch-all.
        assign w_hits[g] = i_region_en[g] &&
                           (({1'b0, w_width} >= c_addr_w) ||
                            ((i_addr >> w_width) == (w_base >> w_width)));
    end

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (w_hits[i]) begin
                o_hit = 1'b1;
                o_idx = 6'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/m68k_region_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | m68k_region_decoder                                                    |
// | Table-driven 68K chip-select decode with wait states, DTACK and BERR.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module m68k_region_decoder
    import m68k_bus_pkg::*;
#(
    parameter int N_REGIONS = 32,
    parameter int ADDR_W    = 24,
    parameter int WAIT_W    = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic [ADDR_W-1:0]           cpu_a,
    input  logic                        cpu_as_n,
    input  logic [N_REGIONS*ADDR_W-1:0] region_base,
    input  logic [N_REGIONS*5-1:0]      region_width,
    input  logic [N_REGIONS*WAIT_W-1:0] region_wait,
    input  logic [N_REGIONS-1:0]        region_en,
    output logic [N_REGIONS-1:0]        cs,
    output logic [5:0]                  region_idx,
    output logic                        cycle_start,
    output logic                        dtack_n,
    output logic                        berr_n
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    logic [2:0]           r_state,   w_state_nxt;
    logic [ADDR_W-1:0]    r_addr,    w_addr_nxt;
    logic [WAIT_W-1:0]    r_wcnt,    w_wcnt_nxt;
    logic [TCNT_W-1:0]    r_tcnt,    w_tcnt_nxt;
    logic [N_REGIONS-1:0] r_cs,      w_cs_nxt;
    logic [5:0]           r_idx,     w_idx_nxt;
    logic                 r_start,   w_start_nxt;
    logic                 r_dtack_n, w_dtack_nxt;
    logic                 r_berr_n,  w_berr_nxt;

    logic                 w_hit;
    logic [5:0]           w_match_idx;
    logic [WAIT_W-1:0]    w_wait_sel;
    logic [N_REGIONS-1:0] w_onehot;

    region_match #(
        .N_REGIONS (N_REGIONS),
        .ADDR_W    (ADDR_W)
    ) u_region_match (
        .i_addr         (r_addr),
        .i_region_base  (region_base),
        .i_region_width (region_width),
        .i_region_en    (region_en),
        .o_hit          (w_hit),
        .o_idx          (w_match_idx)
    );

    always_comb begin
        w_wait_sel = '0;
        w_onehot   = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (w_match_idx == 6'(i)) begin
                w_wait_sel  = region_wait[i*WAIT_W +: WAIT_W];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_wcnt_nxt  = r_wcnt;
        w_tcnt_nxt  = r_tcnt;
        w_cs_nxt    = r_cs;
        w_idx_nxt   = r_idx;
        w_start_nxt = 1'b0;
        w_dtack_nxt = r_dtack_n;
        w_berr_nxt  = r_berr_n;

        case (r_state)
            ST_IDLE: begin
                if (!cpu_as_n) begin
                    w_addr_nxt  = cpu_a;
                    w_state_nxt = ST_MATCH;
                end
            end
            ST_MATCH: begin
                if (cpu_as_n) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_hit) begin
                    w_cs_nxt    = w_onehot;
                    w_idx_nxt   = w_match_idx;
                    w_start_nxt = 1'b1;
                    w_wcnt_nxt  = w_wait_sel;
                    if (w_wait_sel == '0) begin
                        w_state_nxt = ST_ACK;
                        w_dtack_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end else begin
                    w_tcnt_nxt  = TCNT_W'(TIMEOUT);
                    w_state_nxt = ST_MISS;
                end
            end
            ST_WAIT: begin
                w_wcnt_nxt = r_wcnt - WAIT_W'(1);
                if (cpu_as_n) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wcnt == WAIT_W'(1)) begin
                    w_state_nxt = ST_ACK;
                    w_dtack_nxt = 1'b0;
                end
            end
            ST_ACK: begin
                if (cpu_as_n) w_state_nxt = ST_IDLE;
            end
            ST_MISS: begin
                w_tcnt_nxt = r_tcnt - TCNT_W'(1);
                if (cpu_as_n) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_tcnt == TCNT_W'(1)) begin
                    w_state_nxt = ST_BERR;
                    w_berr_nxt  = 1'b0;
                end
            end
            ST_BERR: begin
                if (cpu_as_n) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Every path into IDLE (abort or normal completion) drops the bus outputs.
        if (w_state_nxt == ST_IDLE) begin
            w_cs_nxt    = '0;
            w_dtack_nxt = 1'b1;
            w_berr_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wcnt    <= '0;
            r_tcnt    <= '0;
            r_cs      <= '0;
            r_idx     <= '0;
            r_start   <= 1'b0;
            r_dtack_n <= 1'b1;
            r_berr_n  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_cs      <= w_cs_nxt;
            r_idx     <= w_idx_nxt;
            r_start   <= w_start_nxt;
            r_dtack_n <= w_dtack_nxt;
            r_berr_n  <= w_berr_nxt;
        end
    end

    assign cs          = r_cs;
    assign region_idx  = r_idx;
    assign cycle_start = r_start;
    assign dtack_n     = r_dtack_n;
    assign berr_n      = r_berr_n;

endmodule
`default_nettype wire

// File: tb/tb_m68k_region_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_m68k_region_decoder                                                 |
// | Directed vector table plus hand sequences for abort/reset/back-to-back.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_m68k_region_decoder;

    localparam int TB_N       = 8;
    localparam int TB_AW      = 24;
    localparam int TB_WW      = 4;
    localparam int TB_TIMEOUT = 8;

    typedef struct {
        logic [23:0] addr;
        logic        hit;
        logic [7:0]  cs;
        logic [5:0]  idx;
        int          lat;
    } vec_t;

    logic                    clk_sys = 1'b0;
    logic                    reset_n;
    logic [TB_AW-1:0]        cpu_a;
    logic                    cpu_as_n;
    logic [TB_AW-1:0]        tb_base  [TB_N];
    logic [4:0]              tb_width [TB_N];
    logic [TB_WW-1:0]        tb_wait  [TB_N];
    logic [TB_N-1:0]         region_en;
    logic [TB_N*TB_AW-1:0]   region_base;
    logic [TB_N*5-1:0]       region_width;
    logic [TB_N*TB_WW-1:0]   region_wait;
    logic [TB_N-1:0]         cs;
    logic [5:0]              region_idx;
    logic                    cycle_start;
    logic                    dtack_n;
    logic                    berr_n;

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < TB_N; g++) begin : g_flat
        assign region_base[g*TB_AW +: TB_AW] = tb_base[g];
        assign region_width[g*5 +: 5]        = tb_width[g];
        assign region_wait[g*TB_WW +: TB_WW] = tb_wait[g];
    end

    m68k_region_decoder #(
        .N_REGIONS (TB_N),
        .ADDR_W    (TB_AW),
        .WAIT_W    (TB_WW),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .cpu_a        (cpu_a),
        .cpu_as_n     (cpu_as_n),
        .region_base  (region_base),
        .region_width (region_width),
        .region_wait  (region_wait),
        .region_en    (region_en),
        .cs           (cs),
        .region_idx   (region_idx),
        .cycle_start  (cycle_start),
        .dtack_n      (dtack_n),
        .berr_n       (berr_n)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (reset_n === 1'b1 && dtack_n === 1'b0 && berr_n === 1'b0) begin
            n_errors++;
            $display("FAIL strobe_exclusive: dtack_n=%b berr_n=%b, required not both low", dtack_n, berr_n);
        end
    end

    // Starts and ends at a negedge; AS driven just after a rising edge.
    task automatic run_vec(input vec_t v);
        int  k;
        bit  done;
        @(posedge clk_sys); #1;
        cpu_a    = v.addr;
        cpu_as_n = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check($sformatf("match_cs_quiet@%h", v.addr), 32'(cs), 32'h0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        check($sformatf("cs@%h", v.addr), 32'(cs), 32'(v.cs));
        check($sformatf("cycle_start@%h", v.addr), 32'(cycle_start), 32'(v.hit));
        if (v.hit) check($sformatf("region_idx@%h", v.addr), 32'(region_idx), 32'(v.idx));
        k    = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            if (!dtack_n || !berr_n) done = 1'b1;
            else begin
                @(negedge clk_sys);
                k++;
            end
        end
        check($sformatf("latency@%h", v.addr), 32'(k), 32'(v.lat));
        check($sformatf("strobes@%h", v.addr), {30'h0, dtack_n, berr_n},
              v.hit ? 32'h1 : 32'h2);
        check($sformatf("cs_held@%h", v.addr), 32'(cs), 32'(v.cs));
        @(posedge clk_sys); #1;
        cpu_as_n = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check($sformatf("release@%h", v.addr), {21'h0, cs, cycle_start, dtack_n, berr_n}, 32'h3);
    endtask

    vec_t vecs [13];
    vec_t v;
    bit   seen;

    initial begin
        // 0:1, 1:0x080000/14, 2:0x000000/18 w3, 3 disabled, 4:0x0C0000/16 w1,
        // 5:0x140000/11 w1, 6:0x0D0000 exact, 7 catch-all (off for now)
        tb_base  = '{24'h140000, 24'h080000, 24'h000000, 24'h200000,
                     24'h0C0000, 24'h140000, 24'h0D0000, 24'h000000};
        tb_width = '{5'd1, 5'd14, 5'd18, 5'd20, 5'd16, 5'd11, 5'd0, 5'd24};
        tb_wait  = '{4'd0, 4'd0, 4'd3, 4'd2, 4'd1, 4'd1, 4'd0, 4'd2};
        region_en = 8'b0111_0111;

        vecs[0]  = '{24'h083FFE, 1'b1, 8'h02, 6'd1, 0};
        vecs[1]  = '{24'h084000, 1'b0, 8'h00, 6'd0, TB_TIMEOUT};
        vecs[2]  = '{24'h140000, 1'b1, 8'h01, 6'd0, 0};
        vecs[3]  = '{24'h140001, 1'b1, 8'h01, 6'd0, 0};
        vecs[4]  = '{24'h140002, 1'b1, 8'h20, 6'd5, 1};
        vecs[5]  = '{24'h1407FE, 1'b1, 8'h20, 6'd5, 1};
        vecs[6]  = '{24'h140800, 1'b0, 8'h00, 6'd0, TB_TIMEOUT};
        vecs[7]  = '{24'h03FFFE, 1'b1, 8'h04, 6'd2, 3};
        vecs[8]  = '{24'h200000, 1'b0, 8'h00, 6'd0, TB_TIMEOUT};
        vecs[9]  = '{24'h0CFFFE, 1'b1, 8'h10, 6'd4, 1};
        vecs[10] = '{24'h0D0000, 1'b1, 8'h40, 6'd6, 0};
        vecs[11] = '{24'h0D0001, 1'b0, 8'h00, 6'd0, TB_TIMEOUT};
        vecs[12] = '{24'h144000, 1'b0, 8'h00, 6'd0, TB_TIMEOUT};

        // Reset held with AS asserted
        reset_n  = 1'b0;
        cpu_as_n = 1'b0;
        cpu_a    = 24'h083FFE;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("reset_outputs", {17'h0, cs, region_idx, cycle_start, dtack_n, berr_n}, 32'h3);
        reset_n = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("post_reset_match_cs", 32'(cs), 32'h0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("post_reset_cs_dtack", {23'h0, cs, dtack_n}, {23'h0, 8'h02, 1'b0});
        @(posedge clk_sys); #1;
        cpu_as_n = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("post_reset_release", {22'h0, cs, dtack_n, berr_n}, 32'h3);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Catch-all region 7 at exactly the bus width, then beyond it
        region_en[7] = 1'b1;
        v = '{24'h300000, 1'b1, 8'h80, 6'd7, 2};
        run_vec(v);
        v = '{24'h083FFE, 1'b1, 8'h02, 6'd1, 0};
        run_vec(v);
        tb_width[7] = 5'd31;
        v = '{24'hFFFFFE, 1'b1, 8'h80, 6'd7, 2};
        run_vec(v);
        region_en[7] = 1'b0;
        tb_width[7]  = 5'd24;

        // Abort in MISS: no BERR may follow
        @(posedge clk_sys); #1;
        cpu_a    = 24'h300000;
        cpu_as_n = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1 cpu_as_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk_sys);
            if (!berr_n || cs != '0) seen = 1'b1;
        end
        check("abort_miss_no_berr", 32'(seen), 32'h0);

        // Abort in WAIT: cs drops, DTACK never issued
        @(posedge clk_sys); #1;
        cpu_a    = 24'h03FFFE;
        cpu_as_n = 1'b0;
        @(posedge clk_sys);
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("abort_wait_cs_set", 32'(cs), 32'h04);
        cpu_as_n = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("abort_wait_cleared", {23'h0, cs, dtack_n}, 32'h1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk_sys);
            if (!dtack_n) seen = 1'b1;
        end
        check("abort_wait_no_dtack", 32'(seen), 32'h0);

        // Abort in MATCH: nothing selected
        @(posedge clk_sys); #1;
        cpu_a    = 24'h083FFE;
        cpu_as_n = 1'b0;
        @(posedge clk_sys); #1;
        cpu_as_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk_sys);
            if (cs != '0 || !dtack_n || cycle_start) seen = 1'b1;
        end
        check("abort_match_quiet", 32'(seen), 32'h0);

        // Back-to-back with a table change during ACK
        @(posedge clk_sys); #1;
        cpu_a    = 24'h03FFFE;
        cpu_as_n = 1'b0;
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        check("b2b_first_ack", {23'h0, cs, dtack_n}, {23'h0, 8'h04, 1'b0});
        tb_wait[2] = 4'd0;
        repeat (2) @(negedge clk_sys);
        check("b2b_ack_held_after_table_change", {23'h0, cs, dtack_n}, {23'h0, 8'h04, 1'b0});
        @(posedge clk_sys); #1;
        cpu_as_n = 1'b1;
        @(posedge clk_sys); #1;
        cpu_as_n = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("b2b_match_gap", {22'h0, cs, cycle_start, dtack_n}, 32'h1);
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("b2b_second_start", {22'h0, cs, cycle_start, dtack_n}, {22'h0, 8'h04, 1'b1, 1'b0});
        @(posedge clk_sys); #1;
        cpu_as_n = 1'b1;
        @(posedge clk_sys);
        tb_wait[2] = 4'd3;

        // Reset in the middle of an acknowledged cycle
        @(posedge clk_sys); #1;
        cpu_a    = 24'h083FFE;
        cpu_as_n = 1'b0;
        @(posedge clk_sys);
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("pre_reset_ack", {22'h0, cs, dtack_n, berr_n}, {22'h0, 8'h02, 1'b0, 1'b1});
        reset_n  = 1'b0;
        cpu_as_n = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("midcycle_reset", {17'h0, cs, region_idx, cycle_start, dtack_n, berr_n}, 32'h3);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
